// File: rtl/vta_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vta_mem_arb_pkg
//  Description : Shared types and constants for the VTA simulation-memory
//                DPI arbiter (FSM state encoding, request opcodes).
//  Revision    : 1.0  initial release
// ============================================================================
package vta_mem_arb_pkg;

  // Arbiter sequencing states; the encoding is fixed at two bits.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } arb_state_e;

  // Request opcodes as seen on cl_req_opcode / mem_req_opcode.
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage : vta_mem_arb_pkg
`default_nettype wire

// File: rtl/vta_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : vta_rr_picker
//  Description : Combinational round-robin priority picker. Selects the first
//                set request bit at or after the pointer, scanning upward with
//                wrap, and returns it one-hot together with its index.
//  Revision    : 1.0  initial release
// ============================================================================
module vta_rr_picker #(
  parameter int NUM  = 4,
  parameter int IDXW = 2
) (
  input  logic [NUM-1:0]  i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [NUM-1:0]  o_grant,
  output logic [IDXW-1:0] o_grant_idx,
  output logic            o_any
);

  logic [IDXW-1:0] w_idx;

  // Walk the request vector starting at the pointer; first hit wins.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM; k++) begin
      w_idx = IDXW'((int'(i_ptr) + k) % NUM);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule : vta_rr_picker
`default_nettype wire

// File: rtl/vta_mem_dpi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : vta_mem_dpi_arbiter
//  Description : Round-robin arbiter and burst sequencer sharing the single
//                VTA simulation-memory DPI port among NUM_CLIENTS requesters.
//                One burst at a time: grant, one-cycle DPI request pulse,
//                then write beats from / read beats to the owning client.
//  Revision    : 1.0  initial release
// ============================================================================
module vta_mem_dpi_arbiter
  import vta_mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int LEN_BITS    = 8,
  parameter int ADDR_BITS   = 64,
  parameter int DATA_BITS   = 64
) (
  input  logic                           clock,
  input  logic                           reset,
  // client request channel
  input  logic [NUM_CLIENTS-1:0]         cl_req_valid,
  output logic [NUM_CLIENTS-1:0]         cl_req_ready,
  input  logic [NUM_CLIENTS-1:0]         cl_req_opcode,
  input  logic [NUM_CLIENTS*LEN_BITS-1:0]  cl_req_len,
  input  logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_req_addr,
  // client write channel
  input  logic [NUM_CLIENTS-1:0]         cl_wr_valid,
  input  logic [NUM_CLIENTS*DATA_BITS-1:0] cl_wr_bits,
  output logic [NUM_CLIENTS-1:0]         cl_wr_ready,
  // client read channel
  output logic [NUM_CLIENTS-1:0]         cl_rd_valid,
  output logic [DATA_BITS-1:0]           cl_rd_data,
  output logic                           cl_rd_last,
  input  logic [NUM_CLIENTS-1:0]         cl_rd_ready,
  // DPI memory side
  output logic                           mem_req_valid,
  output logic                           mem_req_opcode,
  output logic [LEN_BITS-1:0]            mem_req_len,
  output logic [LEN_BITS-1:0]            mem_req_id,
  output logic [ADDR_BITS-1:0]           mem_req_addr,
  output logic                           mem_wr_valid,
  output logic [DATA_BITS-1:0]           mem_wr_bits,
  input  logic                           mem_rd_valid,
  input  logic [LEN_BITS-1:0]            mem_rd_id,
  input  logic [DATA_BITS-1:0]           mem_rd_data,
  output logic                           mem_rd_ready,
  // status
  output logic                           err
);

  localparam int c_IDX_BITS = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  localparam logic [1:0] c_ST_IDLE  = IDLE;
  localparam logic [1:0] c_ST_ISSUE = ISSUE;
  localparam logic [1:0] c_ST_WRITE = WRITE;
  localparam logic [1:0] c_ST_READ  = READ;

  localparam logic [c_IDX_BITS-1:0] c_LAST_CLIENT = c_IDX_BITS'(NUM_CLIENTS - 1);

  // registered state
  logic [1:0]            r_state;
  logic [c_IDX_BITS-1:0] r_owner;
  logic                  r_opcode;
  logic [LEN_BITS-1:0]   r_len;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [LEN_BITS-1:0]   r_beat_cnt;
  logic [c_IDX_BITS-1:0] r_rr_ptr;
  logic                  r_err;

  // per-client views of the flattened buses
  logic [LEN_BITS-1:0]   w_len_arr   [NUM_CLIENTS];
  logic [ADDR_BITS-1:0]  w_addr_arr  [NUM_CLIENTS];
  logic [DATA_BITS-1:0]  w_wbits_arr [NUM_CLIENTS];

  generate
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_slice
      assign w_len_arr[gi]   = cl_req_len[gi*LEN_BITS +: LEN_BITS];
      assign w_addr_arr[gi]  = cl_req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign w_wbits_arr[gi] = cl_wr_bits[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // round-robin selection among pending requests
  logic [NUM_CLIENTS-1:0] w_grant;
  logic [c_IDX_BITS-1:0]  w_grant_idx;
  logic                   w_any;

  vta_rr_picker #(
    .NUM  (NUM_CLIENTS),
    .IDXW (c_IDX_BITS)
  ) u_picker (
    .i_req       (cl_req_valid),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  logic                w_req_fire;
  logic                w_wr_fire;
  logic                w_rd_fire;
  logic                w_last;
  logic                w_id_ok;
  logic                w_burst_end;
  logic [LEN_BITS-1:0] w_owner_ext;

  assign w_owner_ext = LEN_BITS'(r_owner);
  assign w_id_ok     = (mem_rd_id == w_owner_ext);
  assign w_last      = (r_beat_cnt == r_len);
  assign w_req_fire  = (r_state == c_ST_IDLE) && w_any;
  assign w_wr_fire   = (r_state == c_ST_WRITE) && cl_wr_valid[r_owner];
  assign w_rd_fire   = (r_state == c_ST_READ) && mem_rd_valid && cl_rd_ready[r_owner];
  assign w_burst_end = (w_wr_fire || w_rd_fire) && w_last;
  assign err         = r_err;

  // Output steering: everything idles at zero; only the owner's lanes are
  // connected through while its burst is active.
  always_comb begin
    cl_req_ready   = '0;
    cl_wr_ready    = '0;
    cl_rd_valid    = '0;
    cl_rd_data     = '0;
    cl_rd_last     = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = '0;
    mem_req_id     = '0;
    mem_req_addr   = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        cl_req_ready = w_grant;
      end
      c_ST_ISSUE: begin
        mem_req_valid  = 1'b1;
        mem_req_opcode = r_opcode;
        mem_req_len    = r_len;
        mem_req_id     = w_owner_ext;
        mem_req_addr   = r_addr;
      end
      c_ST_WRITE: begin
        cl_wr_ready[r_owner] = 1'b1;
        mem_wr_valid         = cl_wr_valid[r_owner];
        mem_wr_bits          = w_wbits_arr[r_owner];
      end
      c_ST_READ: begin
        // A beat tagged for another client is drained but never forwarded.
        mem_rd_ready         = cl_rd_ready[r_owner];
        cl_rd_valid[r_owner] = mem_rd_valid && w_id_ok;
        cl_rd_data           = mem_rd_data;
        cl_rd_last           = w_last;
      end
      default: begin
        cl_req_ready = '0;
      end
    endcase
  end

  // Burst sequencer: capture on grant, pulse the request, count beats.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_owner    <= '0;
      r_opcode   <= OP_RD;
      r_len      <= '0;
      r_addr     <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_req_fire) begin
            r_owner    <= w_grant_idx;
            r_opcode   <= cl_req_opcode[w_grant_idx];
            r_len      <= w_len_arr[w_grant_idx];
            r_addr     <= w_addr_arr[w_grant_idx];
            r_beat_cnt <= '0;
            r_state    <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          r_state <= (r_opcode == OP_WR) ? c_ST_WRITE : c_ST_READ;
        end
        c_ST_WRITE, c_ST_READ: begin
          if (w_wr_fire || w_rd_fire) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
          if (w_burst_end) begin
            r_state  <= c_ST_IDLE;
            r_rr_ptr <= (r_owner == c_LAST_CLIENT) ? '0 : r_owner + 1'b1;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Sticky flag for read beats whose id does not match the current owner.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_rd_fire && !w_id_ok) begin
      r_err <= 1'b1;
    end
  end

endmodule : vta_mem_dpi_arbiter
`default_nettype wire

// File: tb/tb_vta_mem_dpi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vta_mem_dpi_arbiter
//  Description : Scoreboard bench for vta_mem_dpi_arbiter. Stimulus tasks push
//                expected grants, DPI requests, write beats and read beats;
//                a negedge monitor pops and compares as the DUT emits them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vta_mem_dpi_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   cl_req_valid, cl_req_ready, cl_req_opcode;
  logic [31:0]  cl_req_len;
  logic [255:0] cl_req_addr;
  logic [3:0]   cl_wr_valid, cl_wr_ready;
  logic [255:0] cl_wr_bits;
  logic [3:0]   cl_rd_valid, cl_rd_ready;
  logic [63:0]  cl_rd_data;
  logic         cl_rd_last;
  logic         mem_req_valid, mem_req_opcode;
  logic [7:0]   mem_req_len, mem_req_id;
  logic [63:0]  mem_req_addr;
  logic         mem_wr_valid;
  logic [63:0]  mem_wr_bits;
  logic         mem_rd_valid;
  logic [7:0]   mem_rd_id;
  logic [63:0]  mem_rd_data;
  logic         mem_rd_ready;
  logic         err;

  vta_mem_dpi_arbiter #(
    .NUM_CLIENTS (4),
    .LEN_BITS    (8),
    .ADDR_BITS   (64),
    .DATA_BITS   (64)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cl_req_valid   (cl_req_valid),
    .cl_req_ready   (cl_req_ready),
    .cl_req_opcode  (cl_req_opcode),
    .cl_req_len     (cl_req_len),
    .cl_req_addr    (cl_req_addr),
    .cl_wr_valid    (cl_wr_valid),
    .cl_wr_bits     (cl_wr_bits),
    .cl_wr_ready    (cl_wr_ready),
    .cl_rd_valid    (cl_rd_valid),
    .cl_rd_data     (cl_rd_data),
    .cl_rd_last     (cl_rd_last),
    .cl_rd_ready    (cl_rd_ready),
    .mem_req_valid  (mem_req_valid),
    .mem_req_opcode (mem_req_opcode),
    .mem_req_len    (mem_req_len),
    .mem_req_id     (mem_req_id),
    .mem_req_addr   (mem_req_addr),
    .mem_wr_valid   (mem_wr_valid),
    .mem_wr_bits    (mem_wr_bits),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_id      (mem_rd_id),
    .mem_rd_data    (mem_rd_data),
    .mem_rd_ready   (mem_rd_ready),
    .err            (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          id;
    int          len;
    logic        op;
    logic [63:0] addr;
  } req_t;

  typedef struct {
    int          cl;
    logic [63:0] data;
    logic        last;
  } rd_t;

  int          exp_grant_q [$];
  req_t        exp_req_q   [$];
  logic [63:0] exp_wr_q    [$];
  rd_t         exp_rd_q    [$];

  int checks = 0;
  int errors = 0;
  int gcount = 0;
  int rd_count = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    int r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic out_or();
    return |{cl_req_ready, cl_wr_ready, cl_rd_valid, cl_rd_data, cl_rd_last,
             mem_req_valid, mem_req_opcode, mem_req_len, mem_req_id, mem_req_addr,
             mem_wr_valid, mem_wr_bits, mem_rd_ready, err};
  endfunction

  // Monitor: compare every DUT-side event against the scoreboard queues.
  always @(negedge clock) begin
    if (!reset) begin
      if (|(cl_req_valid & cl_req_ready)) begin
        check("req_ready_onehot", 64'($countones(cl_req_ready)), 64'd1);
        if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(oh_idx(cl_req_ready)), 64'hFF);
        else check("grant_order", 64'(oh_idx(cl_req_ready)), 64'(exp_grant_q.pop_front()));
        gcount++;
      end
      if (mem_req_valid) begin
        if (exp_req_q.size() == 0) check("mem_req_unexpected", 64'd1, 64'd0);
        else begin
          req_t r;
          r = exp_req_q.pop_front();
          check("mem_req_id", 64'(mem_req_id), 64'(r.id));
          check("mem_req_len", 64'(mem_req_len), 64'(r.len));
          check("mem_req_opcode", 64'(mem_req_opcode), 64'(r.op));
          check("mem_req_addr", mem_req_addr, r.addr);
        end
      end
      if (mem_wr_valid) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", mem_wr_bits, 64'hFFFF_FFFF);
        else check("wr_data", mem_wr_bits, exp_wr_q.pop_front());
      end
      if (|(cl_rd_valid & cl_rd_ready)) begin
        if (exp_rd_q.size() == 0) check("rd_unexpected", cl_rd_data, 64'hFFFF_FFFF);
        else begin
          rd_t e;
          e = exp_rd_q.pop_front();
          check("rd_client", 64'(oh_idx(cl_rd_valid)), 64'(e.cl));
          check("rd_data", cl_rd_data, e.data);
          check("rd_last", 64'(cl_rd_last), 64'(e.last));
        end
        rd_count++;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Raise a request on client c and wait for its accept edge.
  task automatic req_phase(input int c, input logic op, input int len, input logic [63:0] addr);
    int   t = 0;
    req_t r;
    cl_req_opcode[c]         = op;
    cl_req_len[c*8 +: 8]     = 8'(len);
    cl_req_addr[c*64 +: 64]  = addr;
    cl_req_valid[c]          = 1'b1;
    r.id = c; r.len = len; r.op = op; r.addr = addr;
    exp_grant_q.push_back(c);
    exp_req_q.push_back(r);
    #1;
    while (!cl_req_ready[c] && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) check("req_timeout", 64'd0, 64'd1);
    step();
    cl_req_valid[c] = 1'b0;
  endtask

  // Offer n write beats base, base+1, ... from client c.
  task automatic write_beats(input int c, input int n, input logic [63:0] base, input bit bubble);
    int t;
    for (int b = 0; b < n; b++) begin
      exp_wr_q.push_back(base + 64'(b));
      if (bubble && b == 1) begin
        cl_wr_valid[c] = 1'b0;
        step();
      end
      cl_wr_valid[c]          = 1'b1;
      cl_wr_bits[c*64 +: 64]  = base + 64'(b);
      #1;
      t = 0;
      while (!cl_wr_ready[c] && t < 64) begin
        step();
        t++;
      end
      if (t >= 64) begin
        check("wr_timeout", 64'd0, 64'd1);
        cl_wr_valid[c] = 1'b0;
        return;
      end
      step();
    end
    cl_wr_valid[c] = 1'b0;
  endtask

  // Present len+1 DPI read beats for client c; beat 'bad' carries id 3.
  task automatic read_beats(input int c, input int len, input logic [63:0] base,
                            input bit toggle, input int bad);
    int   t;
    logic rdy = 1'b1;
    rd_t  e;
    for (int b = 0; b <= len; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_id    = (b == bad) ? 8'd3 : 8'(c);
      mem_rd_data  = base + 64'(b);
      if (b != bad) begin
        e.cl = c; e.data = base + 64'(b); e.last = (b == len);
        exp_rd_q.push_back(e);
      end
      t = 0;
      forever begin
        cl_rd_ready[c] = toggle ? rdy : 1'b1;
        rdy = ~rdy;
        #1;
        if ((mem_rd_valid && mem_rd_ready) || t >= 64) break;
        t++;
        step();
      end
      if (t >= 64) begin
        check("rd_timeout", 64'd0, 64'd1);
        mem_rd_valid   = 1'b0;
        cl_rd_ready[c] = 1'b0;
        return;
      end
      if (b == bad) check("bad_beat_hidden", 64'(cl_rd_valid), 64'd0);
      step();
    end
    mem_rd_valid   = 1'b0;
    cl_rd_ready[c] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int gb, t, rc0;
    req_t r;
    reset = 1'b1;
    cl_req_valid = '0; cl_req_opcode = '0; cl_req_len = '0; cl_req_addr = '0;
    cl_wr_valid = '0; cl_wr_bits = '0; cl_rd_ready = '0;
    mem_rd_valid = 1'b0; mem_rd_id = '0; mem_rd_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", 64'(out_or()), 64'd0);
    check("reset_err", 64'(err), 64'd0);
    reset = 1'b0;
    step();

    // single write: client 2, len 3, data A0..A3, with one client stall
    req_phase(2, 1'b1, 3, 64'h1000);
    write_beats(2, 4, 64'hA0, 1'b1);
    check("wr_all_beats", 64'(exp_wr_q.size()), 64'd0);
    check("idle_after_wr", 64'(cl_wr_ready), 64'd0);
    step();

    // single read: client 1, len 0, data DEAD
    req_phase(1, 1'b0, 0, 64'h2000);
    read_beats(1, 0, 64'hDEAD, 1'b0, -1);
    check("rd_single_done", 64'(exp_rd_q.size()), 64'd0);
    check("err_clean", 64'(err), 64'd0);
    step();

    // id mismatch: owner 0, beat 1 tagged 3
    req_phase(0, 1'b0, 3, 64'h3000);
    read_beats(0, 3, 64'h100, 1'b0, 1);
    check("err_set", 64'(err), 64'd1);
    check("mismatch_burst_end", 64'(mem_rd_ready), 64'd0);
    step();

    // maximum length read with toggling client ready
    rc0 = rd_count;
    req_phase(3, 1'b0, 255, 64'h4000);
    read_beats(3, 255, 64'h5000, 1'b1, -1);
    check("max_beats", 64'(rd_count - rc0), 64'd256);
    check("err_sticky", 64'(err), 64'd1);
    step();

    // contention: all four clients request continuously
    for (int i = 0; i < 5; i++) begin
      int g;
      g = i % 4;
      exp_grant_q.push_back(g);
      r.id = g; r.len = 0; r.op = 1'b1; r.addr = 64'h100 * 64'(g);
      exp_req_q.push_back(r);
      exp_wr_q.push_back(64'hC0 + 64'(g));
    end
    for (int c = 0; c < 4; c++) begin
      cl_req_opcode[c]        = 1'b1;
      cl_req_len[c*8 +: 8]    = 8'd0;
      cl_req_addr[c*64 +: 64] = 64'h100 * 64'(c);
      cl_wr_bits[c*64 +: 64]  = 64'hC0 + 64'(c);
    end
    cl_req_valid = 4'hF;
    cl_wr_valid  = 4'hF;
    gb = gcount;
    t  = 0;
    #1;
    while ((gcount - gb) < 5 && t < 200) begin
      step();
      t++;
    end
    cl_req_valid = '0;
    t = 0;
    while (exp_wr_q.size() != 0 && t < 20) begin
      step();
      t++;
    end
    cl_wr_valid = '0;
    check("contention_grants", 64'(gcount - gb), 64'd5);
    step();

    // client 3 alone after owner 0
    req_phase(3, 1'b1, 0, 64'h3300);
    write_beats(3, 1, 64'h33, 1'b0);
    step();

    // client 1 write, leaves pointer at 2
    req_phase(1, 1'b1, 0, 64'h1100);
    write_beats(1, 1, 64'h11, 1'b0);
    step();

    // mid-burst reset during beat 2 of a len 7 write
    req_phase(2, 1'b1, 7, 64'h7000);
    write_beats(2, 2, 64'hE0, 1'b0);
    cl_wr_valid[2]        = 1'b1;
    cl_wr_bits[128 +: 64] = 64'hE2;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("midrst_outputs", 64'(out_or()), 64'd0);
    check("midrst_wr_valid", 64'(mem_wr_valid), 64'd0);
    cl_wr_valid[2] = 1'b0;
    step();

    // after reset the pointer is 0: client 1 beats client 3
    cl_req_opcode[3]      = 1'b1;
    cl_req_len[24 +: 8]   = 8'd0;
    cl_req_valid[3]       = 1'b1;
    req_phase(1, 1'b1, 0, 64'h9000);
    cl_req_valid[3]       = 1'b0;
    write_beats(1, 1, 64'h91, 1'b0);
    step();
    step();

    check("grant_q_empty", 64'(exp_grant_q.size()), 64'd0);
    check("req_q_empty", 64'(exp_req_q.size()), 64'd0);
    check("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    check("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_vta_mem_dpi_arbiter
`default_nettype wire

// File: doc/vta_mem_dpi_arbiter.md
# vta_mem_dpi_arbiter

Round-robin arbiter and transaction sequencer that shares the single VTA simulation memory DPI port among NUM_CLIENTS requesters (load/store/fetch engines). It accepts one burst request at a time and issues it to the DPI port as a one-cycle request pulse tagged with the client index. It then streams write beats from the owning client, or routes read beats back to it, until the burst completes. The block sits between the VTA shell's memory clients and the DPI memory model, in simulation builds only.

## Interface
- NUM_CLIENTS, 4: number of requesters; must be ≥2 and ≤ 2^LEN_BITS.
- LEN_BITS, 8: burst length field width; a burst carries len+1 beats.
- ADDR_BITS, 64: byte address width.
- DATA_BITS, 64: beat width.

Reset is `reset`, synchronous, active-high; clock is `clock`.

- clock  in  1  clock.
- reset  in  1  synchronous active-high reset.
- cl_req_valid  in  NUM_CLIENTS  per-client request valid.
- cl_req_ready  out  NUM_CLIENTS  one-hot request accept.
- cl_req_opcode  in  NUM_CLIENTS  0 = read, 1 = write.
- cl_req_len  in  NUM_CLIENTS*LEN_BITS  beats minus one, client i in slice i.
- cl_req_addr  in  NUM_CLIENTS*ADDR_BITS  start address.
- cl_wr_valid  in  NUM_CLIENTS  write beat valid.
- cl_wr_bits  in  NUM_CLIENTS*DATA_BITS  write beat data.
- cl_wr_ready  out  NUM_CLIENTS  write beat accept (owner only).
- cl_rd_valid  out  NUM_CLIENTS  read beat valid (owner only).
- cl_rd_data  out  DATA_BITS  read beat data, shared by all clients.
- cl_rd_last  out  1  final beat of the current read burst.
- cl_rd_ready  in  NUM_CLIENTS  read beat accept.
- mem_req_valid / mem_req_opcode  out  1 / 1  DPI request pulse and opcode.
- mem_req_len / mem_req_id  out  LEN_BITS each  burst length; owner index, zero-extended.
- mem_req_addr  out  ADDR_BITS  burst address.
- mem_wr_valid / mem_wr_bits  out  1 / DATA_BITS  DPI write beat.
- mem_rd_valid / mem_rd_id / mem_rd_data  in  1 / LEN_BITS / DATA_BITS  DPI read beat.
- mem_rd_ready  out  1  DPI read accept.
- err  out  1  sticky protocol error.

## Operation
- FSM states: IDLE, ISSUE, WRITE, READ.
- **IDLE:**
  - The grant is the first set `cl_req_valid` bit at or after `rr_ptr`, scanning upward with wrap.
  - `cl_req_ready` is asserted one-hot for that client only, combinationally.
  - On handshake, register owner, opcode, len and addr, clear `beat_cnt`, and go to ISSUE.
- **ISSUE:** hold `mem_req_valid` = 1 for exactly this cycle with the registered fields. Go to WRITE if opcode is 1, otherwise READ.
- **WRITE:**
  - `cl_wr_ready[owner]` = 1; `mem_wr_valid` = `cl_wr_valid[owner]`; `mem_wr_bits` = owner's `cl_wr_bits`.
  - Each beat increments `beat_cnt`.
  - The beat where `beat_cnt == len` ends the burst.
- **READ:**
  - `mem_rd_ready` = `cl_rd_ready[owner]`; `cl_rd_valid[owner]` = `mem_rd_valid`; `cl_rd_data` = `mem_rd_data`; `cl_rd_last` = (`beat_cnt == len`).
  - Each DPI handshake increments `beat_cnt`.
  - The handshake with `beat_cnt == len` ends the burst.
  - If a beat's `mem_rd_id` ≠ owner: the beat is consumed and counted, `cl_rd_valid` stays 0 for it, and `err` is set.
- **Burst end:** go to IDLE and set `rr_ptr` = (owner+1) mod NUM_CLIENTS.
- **Non-owner clients:** `cl_req_ready`, `cl_wr_ready` and `cl_rd_valid` are always 0 outside the states above and for non-owners.
- **Outside READ:** `mem_rd_ready` = 0, so any DPI read beat is held by the DPI side.
- **Widths:** `beat_cnt` is LEN_BITS wide and compared against len, so len = 2^LEN_BITS−1 yields 2^LEN_BITS beats with no wrap before termination.
- **`err`:** cleared only by reset.

## Timing
- **Reset values:** state IDLE, `rr_ptr` 0, `beat_cnt` 0, `err` 0. All outputs are 0: request, write, read and ready signals, `mem_req_*` fields, `cl_rd_data` and `cl_rd_last`.
- **Reset mid-burst:** immediate return to IDLE. The partial burst is abandoned and no completion is signalled.
- **Request path:** accept cycle N → `mem_req_valid` at N+1 → first write beat can transfer at N+2.
- **Back-to-back:** the next grant is possible in the cycle after the burst end, so the minimum gap is one IDLE cycle.
- **Write beats:** `mem_wr_valid` is combinational from the owner's valid with zero added latency. Write stalls are client-driven only, since the DPI side has no write backpressure.
- **Read beats:** read data passes combinationally through the block. The DPI side's own one-cycle output register gives the end-to-end latency.
- **Fairness:** with all clients requesting continuously, grants rotate 0,1,2,3,0,…

## Structure
- Package `vta_mem_arb_pkg` holds:
  - the state enum `arb_state_e` {IDLE, ISSUE, WRITE, READ};
  - constants `OP_RD`=1'b0 and `OP_WR`=1'b1.
- Sub-module `vta_rr_picker`: combinational round-robin priority picker taking request vector and pointer, producing a one-hot grant and its index. The pointer register stays in the parent.

## Test plan
- **Single write:** client 2 write, len=3, addr 0x1000, data 0xA0..0xA3 → one `mem_req_valid` pulse with id=2, len=3, opcode=1; four `mem_wr_valid` beats in order; return to IDLE.
- **Single read:** client 1 read, len=0 → DPI beat with id=1, data 0xDEAD appears on `cl_rd_valid[1]` with `cl_rd_last`=1; `err` stays 0.
- **Contention:** all four clients request continuously → grant order 0,1,2,3,0. Client 3 alone after owner 0 → granted next.
- **Backpressure and maximum length:** read len=255 with `cl_rd_ready` toggling every other cycle → exactly 256 beats delivered, `cl_rd_last` only on beat 256, no beat lost.
- **Id mismatch:** one beat with id=3 while owner is 0 → beat not forwarded, `err`=1 and stays 1, burst still terminates after len+1 beats.
- **Mid-burst reset:** reset asserted during beat 2 of a len=7 write → next cycle state is IDLE, all outputs 0, `rr_ptr`=0; a new request is granted normally.
